// File: rtl/vending_pkg.sv
// vending_pkg: state encoding, default widths and the price-slicing helper
// shared by the vending machine RTL.
package vending_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t READY  = 2'd1;
  localparam state_t MAKE   = 2'd2;
  localparam state_t PAYOUT = 2'd3;

  localparam int unsigned DEF_VAL_W     = 16;
  localparam int unsigned DEF_COIN_UNIT = 100;

  // Widest packed price vector the helper accepts (N_PROD * VAL_W).
  localparam int unsigned PRICES_MAX_W = 512;

  // Returns price number idx from a packed vector of val_w-wide fields.
  function automatic logic [31:0] price_slice(input logic [PRICES_MAX_W-1:0] prices,
                                              input int unsigned idx,
                                              input int unsigned val_w);
    logic [31:0] mask;
    mask = (val_w >= 32) ? '1 : ((32'd1 << val_w) - 32'd1);
    return 32'(prices >> (idx * val_w)) & mask;
  endfunction

endpackage

// File: rtl/vending_machine_rise_detect.sv
// rise_detect: one-flop rising-edge detector for the level coin sensor.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Remember the previous sample of the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/vending_machine.sv
// vending_machine: multi-product vending controller with coin counting,
// balance cap, per-product prices and multi-coin change payout.
// Optional dispense watchdog enabled by defining DISPENSE_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | balance is zero, waiting for a coin
//   READY  | balance > 0, accepting coins, selection or return request
//   MAKE   | make command held until the dispense-complete sensor fires
//   PAYOUT | paying change one COIN_UNIT per coin_return pulse
module vending_machine
  import vending_pkg::*;
#(
  parameter int unsigned                  N_PROD    = 4,
  parameter int unsigned                  VAL_W     = DEF_VAL_W,
  parameter int unsigned                  COIN_UNIT = DEF_COIN_UNIT,
  parameter int unsigned                  MAX_BAL   = 1000,
  parameter logic [N_PROD*VAL_W-1:0]      PRICES    = {16'd600, 16'd500, 16'd400, 16'd300},
  parameter int unsigned                  TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coin,
  input  logic              return_coin_btn,
  input  logic [N_PROD-1:0] sel_btn,
  input  logic              prod_out,
  output logic [VAL_W-1:0]  coin_val,
  output logic              seg_en,
  output logic [N_PROD-1:0] make,
  output logic              coin_return,
  output logic              reject,
  output logic              insufficient,
  output logic              fault
);

  localparam int unsigned IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  if ((longint'(MAX_BAL) >= (longint'(1) << VAL_W)) || (N_PROD * VAL_W > PRICES_MAX_W)
      || (TIMEOUT == 0)) begin : g_bad_cfg
    $error("vending_machine: MAX_BAL must fit in VAL_W, prices must fit, TIMEOUT nonzero");
  end

  logic [VAL_W-1:0] price_arr [N_PROD];

  for (genvar gi = 0; gi < N_PROD; gi++) begin : g_price
    localparam logic [31:0] P32 = price_slice(PRICES_MAX_W'(PRICES), gi, VAL_W);
    assign price_arr[gi] = VAL_W'(P32);
    if ((P32 == 0) || ((P32 % COIN_UNIT) != 0)) begin : g_bad_price
      $error("vending_machine: price %0d is not a nonzero multiple of COIN_UNIT", gi);
    end
  end

  state_t            state_q, state_d;
  logic [VAL_W-1:0]  coin_val_q, coin_val_d;
  logic [N_PROD-1:0] make_q, make_d;
  logic              coin_return_q, coin_return_d;
  logic              reject_q, reject_d;
  logic              insufficient_q, insufficient_d;
  logic              fault_q, fault_d;
  logic              seg_en_q, seg_en_d;

  logic              coin_edge;
  logic [IDX_W-1:0]  sel_idx;
  logic [VAL_W-1:0]  sel_price, refund;
  logic [VAL_W:0]    bal_inc;
  logic [VAL_W-1:0]  bal_dec;
  logic              coin_fits, sel_any, bal_enough, tmo_expired;

  rise_detect u_coin_rise (
    .clk   (clk),
    .rst_n (reset),
    .d     (coin),
    .rise  (coin_edge)
  );

  // Selection decode, refund lookup and balance arithmetic shared by the FSM.
  always_comb begin
    sel_idx = '0;
    for (int i = N_PROD - 1; i >= 0; i--) begin
      if (sel_btn[i]) sel_idx = IDX_W'(i);
    end
    refund = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (make_q[i]) refund = refund | price_arr[i];
    end
    sel_price  = price_arr[sel_idx];
    sel_any    = |sel_btn;
    bal_enough = coin_val_q >= sel_price;
    bal_inc    = {1'b0, coin_val_q} + (VAL_W+1)'(COIN_UNIT);
    coin_fits  = bal_inc <= (VAL_W+1)'(MAX_BAL);
    bal_dec    = (coin_val_q >= VAL_W'(COIN_UNIT)) ? coin_val_q - VAL_W'(COIN_UNIT) : '0;
  end

`ifdef DISPENSE_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_expired = (tmo_cnt_q == '0);

  // Watchdog down-counter: reload on entry to MAKE, count down while waiting.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q != MAKE) && (state_d == MAKE))  tmo_cnt_d = TMO_W'(TIMEOUT - 1);
    else if ((state_q == MAKE) && !tmo_expired) tmo_cnt_d = tmo_cnt_q - 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  // Without the watchdog MAKE never expires, so fault stays low.
  assign tmo_expired = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      coin_val_q     <= '0;
      make_q         <= '0;
      coin_return_q  <= 1'b0;
      reject_q       <= 1'b0;
      insufficient_q <= 1'b0;
      fault_q        <= 1'b0;
      seg_en_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      coin_val_q     <= coin_val_d;
      make_q         <= make_d;
      coin_return_q  <= coin_return_d;
      reject_q       <= reject_d;
      insufficient_q <= insufficient_d;
      fault_q        <= fault_d;
      seg_en_q       <= seg_en_d;
    end
  end

  // Next-state logic; READY arbitration is return, then selection, then coin.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (coin_edge && coin_fits) state_d = READY;
      READY: begin
        if (return_coin_btn)           state_d = PAYOUT;
        else if (sel_any && bal_enough) state_d = MAKE;
      end
      MAKE: begin
        if (prod_out)         state_d = (coin_val_q != '0) ? READY : IDLE;
        else if (tmo_expired) state_d = READY;
      end
      PAYOUT:  if (!coin_return_q && (coin_val_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and balance updates; pulses default low so each lasts one cycle.
  always_comb begin
    coin_val_d     = coin_val_q;
    make_d         = make_q;
    coin_return_d  = 1'b0;
    reject_d       = 1'b0;
    insufficient_d = 1'b0;
    fault_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (coin_edge) begin
          if (coin_fits) coin_val_d = bal_inc[VAL_W-1:0];
          else           reject_d   = 1'b1;
        end
      end
      READY: begin
        if (return_coin_btn) begin
          coin_return_d = 1'b1;
          coin_val_d    = bal_dec;
          reject_d      = coin_edge;
        end else if (sel_any) begin
          reject_d = coin_edge;
          if (bal_enough) begin
            coin_val_d = coin_val_q - sel_price;
            make_d     = N_PROD'(1) << sel_idx;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (coin_edge) begin
          if (coin_fits) coin_val_d = bal_inc[VAL_W-1:0];
          else           reject_d   = 1'b1;
        end
      end
      MAKE: begin
        reject_d = coin_edge;
        if (prod_out) begin
          make_d = '0;
        end else if (tmo_expired) begin
          make_d     = '0;
          coin_val_d = coin_val_q + refund;
          fault_d    = 1'b1;
        end
      end
      PAYOUT: begin
        reject_d = coin_edge;
        if (!coin_return_q && (coin_val_q != '0)) begin
          coin_return_d = 1'b1;
          coin_val_d    = bal_dec;
        end
      end
      default: ;
    endcase
    seg_en_d = (state_d != IDLE);
  end

  assign coin_val     = coin_val_q;
  assign seg_en       = seg_en_q;
  assign make         = make_q;
  assign coin_return  = coin_return_q;
  assign reject       = reject_q;
  assign insufficient = insufficient_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: table-driven, directed and randomized checks of the
// vending machine against a behavioural model of its selling rules.
module tb_vending_machine;

  localparam int N_PROD  = 4;
  localparam int VAL_W   = 16;
  localparam int CU      = 100;
  localparam int MAX_BAL = 1000;
`ifdef DISPENSE_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 1000;
`endif

  int price_tab [N_PROD] = '{300, 400, 500, 600};

  logic              clk = 1'b0;
  logic              reset;
  logic              coin, ret, prod;
  logic [N_PROD-1:0] sel;
  logic [VAL_W-1:0]  coin_val;
  logic              seg_en, coin_return, reject, insufficient, fault;
  logic [N_PROD-1:0] make;

  int n_checks = 0;
  int n_errors = 0;

  vending_machine #(
    .N_PROD    (N_PROD),
    .VAL_W     (VAL_W),
    .COIN_UNIT (CU),
    .MAX_BAL   (MAX_BAL),
    .PRICES    ({16'd600, 16'd500, 16'd400, 16'd300}),
    .TIMEOUT   (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .coin            (coin),
    .return_coin_btn (ret),
    .sel_btn         (sel),
    .prod_out        (prod),
    .coin_val        (coin_val),
    .seg_en          (seg_en),
    .make            (make),
    .coin_return     (coin_return),
    .reject          (reject),
    .insufficient    (insufficient),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  // mode 0: taking coins (idle when balance is 0), 1: dispensing, 2: paying change
  int          m_bal, m_mode, m_waited, m_idx;
  bit          m_prev;
  logic [3:0]  m_make;
  int          payq[$];
  bit          e_cr, e_rej, e_ins, e_fault;

  task automatic model_reset();
    m_bal = 0; m_mode = 0; m_waited = 0; m_idx = 0; m_prev = 0; m_make = '0;
    payq.delete();
    e_cr = 0; e_rej = 0; e_ins = 0; e_fault = 0;
  endtask

  task automatic pay_pop();
    e_cr = payq.pop_front() != 0;
    if (e_cr) m_bal = (m_bal > CU) ? m_bal - CU : 0;
  endtask

  task automatic model_step();
    bit edge_s;
    int idx;
    edge_s = coin && !m_prev;
    m_prev = coin;
    e_cr = 0; e_rej = 0; e_ins = 0; e_fault = 0;
    if (m_mode == 0) begin
      if (m_bal > 0 && ret) begin
        payq.delete();
        for (int k = 0; k < (m_bal + CU - 1) / CU; k++) begin
          payq.push_back(1); payq.push_back(0);
        end
        m_mode = 2;
        e_rej  = edge_s;
        pay_pop();
      end else if (m_bal > 0 && sel != 0) begin
        e_rej = edge_s;
        idx = -1;
        for (int i = 0; i < N_PROD; i++) if (sel[i] && idx < 0) idx = i;
        if (m_bal >= price_tab[idx]) begin
          m_bal   -= price_tab[idx];
          m_make   = 4'(1 << idx);
          m_idx    = idx;
          m_mode   = 1;
          m_waited = 0;
        end else begin
          e_ins = 1;
        end
      end else if (edge_s) begin
        if (m_bal + CU <= MAX_BAL) m_bal += CU;
        else                       e_rej = 1;
      end
    end else if (m_mode == 1) begin
      e_rej = edge_s;
      if (prod) begin
        m_make = '0; m_mode = 0;
      end
`ifdef DISPENSE_TIMEOUT_EN
      else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_bal += price_tab[m_idx]; m_make = '0; e_fault = 1; m_mode = 0;
        end
      end
`endif
    end else begin
      e_rej = edge_s;
      if (payq.size() == 0) m_mode = 0;
      else                  pay_pop();
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model coin_val",     32'(coin_val),     32'(m_bal));
    chk("model make",         32'(make),         32'(m_make));
    chk("model coin_return",  32'(coin_return),  32'(e_cr));
    chk("model reject",       32'(reject),       32'(e_rej));
    chk("model insufficient", 32'(insufficient), 32'(e_ins));
    chk("model fault",        32'(fault),        32'(e_fault));
    chk("model seg_en",       32'(seg_en),       32'((m_mode != 0) || (m_bal != 0)));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic insert_coin();
    coin = 1'b1; cycle();
    coin = 1'b0; cycle();
  endtask

  // Issue a return request and count coin_return pulses until the display goes dark.
  task automatic payout(output int pulses, output bit adjacent, output bit timed_out);
    bit prev;
    ret = 1'b1; cycle(); ret = 1'b0;
    sel = '0;
    pulses = coin_return ? 1 : 0;
    prev = coin_return; adjacent = 0; timed_out = 1;
    for (int c = 0; c < 100; c++) begin
      cycle();
      if (coin_return) pulses++;
      if (coin_return && prev) adjacent = 1;
      prev = coin_return;
      if (!seg_en) begin timed_out = 0; break; end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         coin;
    bit         ret;
    logic [3:0] sel;
    bit         prod;
    int         exp_bal;
    logic [3:0] exp_make;
    bit         exp_ins;
    bit         exp_seg;
  } vec_t;

  vec_t tab[$];

  task automatic add_vec(input bit c, input bit r, input logic [3:0] s, input bit p,
                         input int b, input logic [3:0] m, input bit ins, input bit sg);
    vec_t v;
    v.coin = c; v.ret = r; v.sel = s; v.prod = p;
    v.exp_bal = b; v.exp_make = m; v.exp_ins = ins; v.exp_seg = sg;
    tab.push_back(v);
  endtask

  int pulses;
  bit adjacent, tmo;
  logic [3:0] make_seen;
  int fault_at;

  initial begin
    reset = 1'b0; coin = 0; ret = 0; sel = '0; prod = 0;
    model_reset();

    //        coin ret sel     prod bal  make    ins seg
    add_vec(1, 0, 4'b0000, 0, 100, 4'b0000, 0, 1);
    add_vec(1, 0, 4'b0000, 0, 100, 4'b0000, 0, 1);
    add_vec(1, 0, 4'b0000, 0, 100, 4'b0000, 0, 1);
    add_vec(0, 0, 4'b0000, 0, 100, 4'b0000, 0, 1);
    add_vec(1, 0, 4'b0000, 0, 200, 4'b0000, 0, 1);
    add_vec(1, 0, 4'b0000, 0, 200, 4'b0000, 0, 1);
    add_vec(1, 0, 4'b0000, 0, 200, 4'b0000, 0, 1);
    add_vec(0, 0, 4'b0000, 0, 200, 4'b0000, 0, 1);
    add_vec(1, 0, 4'b0000, 0, 300, 4'b0000, 0, 1);
    add_vec(0, 0, 4'b0000, 0, 300, 4'b0000, 0, 1);
    add_vec(0, 0, 4'b0010, 0, 300, 4'b0000, 1, 1);
    add_vec(0, 0, 4'b0000, 0, 300, 4'b0000, 0, 1);
    add_vec(1, 0, 4'b0000, 0, 400, 4'b0000, 0, 1);
    add_vec(0, 0, 4'b0000, 0, 400, 4'b0000, 0, 1);
    add_vec(0, 0, 4'b0010, 0,   0, 4'b0010, 0, 1);
    add_vec(0, 0, 4'b0000, 0,   0, 4'b0010, 0, 1);
    add_vec(0, 0, 4'b0000, 1,   0, 4'b0000, 0, 0);
    add_vec(0, 0, 4'b0000, 0,   0, 4'b0000, 0, 0);

    #50;
    chk("reset coin_val",    32'(coin_val),    0);
    chk("reset make",        32'(make),        0);
    chk("reset seg_en",      32'(seg_en),      0);
    chk("reset coin_return", 32'(coin_return), 0);
    chk("reset reject",      32'(reject),      0);
    chk("reset fault",       32'(fault),       0);
    #50;
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < tab.size(); i++) begin
      coin = tab[i].coin; ret = tab[i].ret; sel = tab[i].sel; prod = tab[i].prod;
      cycle();
      chk($sformatf("tab[%0d] coin_val", i),     32'(coin_val),     32'(tab[i].exp_bal));
      chk($sformatf("tab[%0d] make", i),         32'(make),         32'(tab[i].exp_make));
      chk($sformatf("tab[%0d] insufficient", i), 32'(insufficient), 32'(tab[i].exp_ins));
      chk($sformatf("tab[%0d] seg_en", i),       32'(seg_en),       32'(tab[i].exp_seg));
    end
    coin = 0; ret = 0; sel = '0; prod = 0;

    // Fill to the cap, refuse an eleventh coin, then pay out everything.
    for (int k = 1; k <= 10; k++) begin
      insert_coin();
      chk("fill coin_val", 32'(coin_val), 32'(k * CU));
    end
    coin = 1'b1; cycle();
    chk("cap reject",   32'(reject),   1);
    chk("cap coin_val", 32'(coin_val), 1000);
    coin = 1'b0; cycle();
    chk("cap reject cleared", 32'(reject), 0);
    payout(pulses, adjacent, tmo);
    chk("payout1000 pulses",   32'(pulses),   10);
    chk("payout1000 adjacent", 32'(adjacent), 0);
    chk("payout1000 timeout",  32'(tmo),      0);
    chk("payout1000 coin_val", 32'(coin_val), 0);

    // Return beats a simultaneous selection.
    for (int k = 0; k < 5; k++) insert_coin();
    sel = 4'b0011;
    make_seen = '0;
    ret = 1'b1; cycle(); ret = 1'b0; sel = '0;
    make_seen |= make;
    pulses = coin_return ? 1 : 0; tmo = 1;
    for (int c = 0; c < 100; c++) begin
      cycle();
      make_seen |= make;
      if (coin_return) pulses++;
      if (!seg_en) begin tmo = 0; break; end
    end
    chk("return-wins pulses",  32'(pulses),    5);
    chk("return-wins make",    32'(make_seen), 0);
    chk("return-wins timeout", 32'(tmo),       0);

    // Dispense without prod_out.
    for (int k = 0; k < 3; k++) insert_coin();
    sel = 4'b0001; cycle(); sel = '0;
    chk("sel0 make",     32'(make),     32'(4'b0001));
    chk("sel0 coin_val", 32'(coin_val), 0);
`ifdef DISPENSE_TIMEOUT_EN
    fault_at = -1;
    for (int c = 1; c <= 200; c++) begin
      cycle();
      if (fault) begin fault_at = c; break; end
    end
    chk("watchdog cycle",    32'(fault_at), 32'(TMO));
    chk("watchdog coin_val", 32'(coin_val), 300);
    chk("watchdog make",     32'(make),     0);
    chk("watchdog seg_en",   32'(seg_en),   1);
    cycle();
    chk("watchdog fault one cycle", 32'(fault), 0);
    sel = 4'b0001; cycle(); sel = '0;
    for (int c = 1; c < TMO; c++) cycle();
    prod = 1'b1; cycle(); prod = 1'b0;
    chk("expiry-race fault",    32'(fault),    0);
    chk("expiry-race make",     32'(make),     0);
    chk("expiry-race coin_val", 32'(coin_val), 0);
    chk("expiry-race seg_en",   32'(seg_en),   0);
`else
    fault_at = 0;
    for (int c = 0; c < 200; c++) begin
      cycle();
      if (fault) fault_at++;
    end
    chk("no-watchdog make held", 32'(make),     32'(4'b0001));
    chk("no-watchdog fault",     32'(fault_at), 0);
    prod = 1'b1; cycle(); prod = 1'b0;
    chk("no-watchdog done make", 32'(make),   0);
    chk("no-watchdog done seg",  32'(seg_en), 0);
`endif

    // Asynchronous reset in the middle of a payout.
    for (int k = 0; k < 3; k++) insert_coin();
    ret = 1'b1; cycle(); ret = 1'b0;
    cycle(); cycle();
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk("async rst coin_val",    32'(coin_val),    0);
    chk("async rst coin_return", 32'(coin_return), 0);
    chk("async rst make",        32'(make),        0);
    chk("async rst seg_en",      32'(seg_en),      0);
    chk("async rst reject",      32'(reject),      0);
    chk("async rst insufficient",32'(insufficient),0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cycle();
    chk("post-rst coin_val", 32'(coin_val), 0);
    chk("post-rst seg_en",   32'(seg_en),   0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      coin = 1'($urandom_range(0, 1));
      ret  = ($urandom_range(0, 39) == 0);
      sel  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      prod = (c < 1500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 79) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
# vending_machine

Parametrised successor to the single-product coffee controller: a multi-product vending FSM with a configurable coin unit, per-product prices, balance cap, multi-coin change payout and an optional dispense watchdog. It sits between the debounced front-panel inputs (coin sensor, product buttons, return button, dispense-complete sensor) and the FND driver and actuator outputs.

## Interface
- N_PROD, 4, number of products
- VAL_W, 16, balance and price width
- COIN_UNIT, 100, value credited per coin
- MAX_BAL, 1000, balance cap
- PRICES, {16'd600,16'd500,16'd400,16'd300}, packed prices; product i = PRICES[i*VAL_W +: VAL_W], every price a nonzero multiple of COIN_UNIT
- TIMEOUT, 1000, dispense watchdog limit in cycles
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- coin  in  1  coin sensor, level; each rising edge is one coin
- return_coin_btn  in  1  change request
- sel_btn  in  N_PROD  product buttons; lowest set index wins
- prod_out  in  1  dispense-complete sensor
- coin_val  out  VAL_W  current balance
- seg_en  out  1  FND enable
- make  out  N_PROD  one-hot product-make command
- coin_return  out  1  one pulse per COIN_UNIT paid out
- reject  out  1  1-cycle pulse when a coin is refused
- insufficient  out  1  1-cycle pulse when a selection is refused for low balance
- fault  out  1  1-cycle pulse on watchdog expiry

## Operation
- States: IDLE (balance 0), READY (balance > 0), MAKE, PAYOUT.
- A coin edge means coin is 1 at the current edge and was 0 at the previous one.
- IDLE/READY, coin edge: if coin_val + COIN_UNIT ≤ MAX_BAL, add COIN_UNIT and go to READY. Otherwise pulse reject and leave the balance unchanged.
- READY priority: return_coin_btn, then sel_btn, then coin edge. A coin edge that loses arbitration is rejected with a reject pulse.
- READY, sel_btn index i:
  - If coin_val ≥ price[i]: subtract price[i], set make = 1<<i, go to MAKE.
  - Otherwise: pulse insufficient and stay in READY.
- sel_btn in IDLE is ignored.
- MAKE: make is held until prod_out is sampled 1. Then make clears and the FSM goes to READY if balance > 0, else IDLE. Coin edges are rejected; buttons are ignored.
- PAYOUT: coin_return toggles 1,0,1,0,… Each high cycle subtracts COIN_UNIT, saturating at 0. After the last pulse the FSM goes to IDLE. Coins are rejected; buttons are ignored.
- return_coin_btn with balance 0 (IDLE) is ignored.
- seg_en = 1 in every state except IDLE.

## Timing
- Reset values: coin_val 0, make 0, coin_return 0, reject 0, insufficient 0, fault 0, seg_en 0, state IDLE. Reset mid-MAKE or mid-PAYOUT drops the balance immediately.
- Every output is registered.
- Coin latency: coin_val changes at the same edge that detects the coin edge.
- Selection latency: make and the balance deduction appear 1 cycle after sel_btn is sampled.
- Dispense completion: make drops at the edge that samples prod_out = 1.
- Payout: the first coin_return high comes 1 cycle after the return request is sampled. Balance B takes 2·⌈B/COIN_UNIT⌉ cycles, then IDLE on the next edge.
- Each pulse output lasts exactly one cycle per event.

## Configuration
- DISPENSE_TIMEOUT_EN defined:
  - A counter runs in MAKE. If prod_out is not seen within TIMEOUT cycles, the machine refunds price[i] to the balance, clears make, pulses fault and goes to READY.
  - prod_out on the expiry cycle wins: normal completion, no refund.
- DISPENSE_TIMEOUT_EN undefined: MAKE waits indefinitely, fault is tied to 0, and TIMEOUT is unused.

## Structure
- Package vending_pkg holds:
  - the state encoding localparams (IDLE, READY, MAKE, PAYOUT);
  - default VAL_W and COIN_UNIT;
  - the price-slicing function.
- One sub-module, rise_detect: a one-flop rising-edge detector used for coin.
- Elaboration check: every price is a multiple of COIN_UNIT, and MAX_BAL < 2^VAL_W.

## Test plan
- Reset low 100 ns, release on negedge; insert 3 coins (3 clocks high each) → coin_val 100, 200, 300; seg_en 1 after the first coin.
- At 300, press sel_btn = 4'b0010 (price 400) → insufficient pulse, coin_val stays 300; add a coin, press again → make = 4'b0010, coin_val 0; prod_out pulse → make 0, IDLE, seg_en 0.
- Insert 10 coins (1000), then an 11th → reject pulse, coin_val stays 1000; press return → exactly 10 coin_return pulses, coin_val 0, IDLE.
- Balance 500, sel_btn = 4'b0011 together with return_coin_btn → return wins: 5 coin_return pulses, make stays 0.
- With DISPENSE_TIMEOUT_EN and TIMEOUT = 50, balance 300: select product 0, withhold prod_out → fault pulse at cycle 50, coin_val 300, READY.
- Assert reset mid-PAYOUT at balance 300 → all outputs 0 asynchronously, coin_val 0, IDLE after release.
